mem_arb_2to1: RTL and testbench

//  Shares one mem_req_t/mem_resp_t slave port between two masters (m0, m1).

---
 rtl/mem_arb_2to1.sv | 135 +++++++++++++
 tb/tb_mem_arb_2to1.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb_2to1.sv
// Two-master round-robin arbiter for a single in-order mem slave; optional MEM_ARB_PERF_EN counters.
// Zero-latency request mux and response demux; response order is kept in a master-ID FIFO.
// Backpressure: an unaccepted request locks the grant; requests stall while OUTSTD are outstanding.
package mem_arb_pkg;
  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } mem_resp_t;
endpackage

module mem_arb_2to1
  import mem_arb_pkg::*;
#(
  parameter int OUTSTD = 4
) (
  input  logic      clk,
  input  logic      rstn,
  input  logic      m0_req_valid,
  output logic      m0_req_ready,
  input  mem_req_t  m0_req,
  output logic      m0_resp_valid,
  input  logic      m0_resp_ready,
  output mem_resp_t m0_resp,
  input  logic      m1_req_valid,
  output logic      m1_req_ready,
  input  mem_req_t  m1_req,
  output logic      m1_resp_valid,
  input  logic      m1_resp_ready,
  output mem_resp_t m1_resp,
  output logic      sn_req_valid,
  input  logic      sn_req_ready,
  output mem_req_t  sn_req,
  input  logic      sn_resp_valid,
  output logic      sn_resp_ready,
  input  mem_resp_t sn_resp,
  output logic      err_unexp_resp
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0] perf_gnt0,
  output logic [31:0] perf_gnt1,
  output logic [31:0] perf_conf,
  output logic [31:0] perf_full
`endif
);

  localparam int IDX_W = $clog2(OUTSTD) + 1;
  localparam int AW    = (OUTSTD > 1) ? $clog2(OUTSTD) : 1;

  logic             lock, lock_id, rr_ptr, grant;
  logic [IDX_W-1:0] wptr, rptr, cnt;
  logic             fifo_mem [2**AW];
  logic             full, empty, head, req_hs, resp_hs;

  assign cnt   = wptr - rptr;
  assign full  = (cnt == IDX_W'(OUTSTD));
  assign empty = (cnt == '0);
  assign head  = fifo_mem[rptr[AW-1:0]];

  // A stalled request keeps its grant so the master's valid/payload stay paired.
  always_comb begin
    grant = 1'b0;
    if (lock)                              grant = lock_id;
    else if (m0_req_valid && m1_req_valid) grant = rr_ptr;
    else if (m1_req_valid)                 grant = 1'b1;
  end

  assign sn_req_valid = (grant ? m1_req_valid : m0_req_valid) && !full;
  assign sn_req       = grant ? m1_req : m0_req;
  assign m0_req_ready = sn_req_ready && !full && !grant;
  assign m1_req_ready = sn_req_ready && !full && grant;
  assign req_hs       = sn_req_valid && sn_req_ready;

  assign m0_resp_valid = sn_resp_valid && !empty && !head;
  assign m1_resp_valid = sn_resp_valid && !empty && head;
  assign m0_resp       = sn_resp;
  assign m1_resp       = sn_resp;
  // With nothing outstanding, a slave response is swallowed and flagged.
  assign sn_resp_ready = empty ? sn_resp_valid : (head ? m1_resp_ready : m0_resp_ready);
  assign resp_hs       = sn_resp_valid && sn_resp_ready && !empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lock           <= 1'b0;
      lock_id        <= 1'b0;
      rr_ptr         <= 1'b0;
      wptr           <= '0;
      rptr           <= '0;
      err_unexp_resp <= 1'b0;
    end else begin
      if (req_hs) begin
        lock   <= 1'b0;
        rr_ptr <= ~grant;
        wptr   <= wptr + IDX_W'(1);
      end else if (sn_req_valid) begin
        lock    <= 1'b1;
        lock_id <= grant;
      end
      if (resp_hs)
        rptr <= rptr + IDX_W'(1);
      if (sn_resp_valid && empty)
        err_unexp_resp <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (req_hs)
      fifo_mem[wptr[AW-1:0]] <= grant;
  end

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_gnt0 <= '0;
      perf_gnt1 <= '0;
      perf_conf <= '0;
      perf_full <= '0;
    end else begin
      perf_gnt0 <= perf_gnt0 + 32'(req_hs && !grant);
      perf_gnt1 <= perf_gnt1 + 32'(req_hs && grant);
      perf_conf <= perf_conf + 32'(m0_req_valid && m1_req_valid && !full);
      perf_full <= perf_full + 32'((m0_req_valid || m1_req_valid) && full);
    end
  end
`else
  // No performance counters in this build; arbitration is unaffected.
`endif

endmodule

// File: tb/tb_mem_arb_2to1.sv
// Bench for mem_arb_2to1: queue-based reference model checked every cycle plus directed scenarios.
module tb_mem_arb_2to1;
  import mem_arb_pkg::*;

  localparam int OUTSTD = 4;
  localparam logic [31:0] RSP_OFS = 32'h1000_0000;

  logic      clk = 1'b0;
  logic      rstn = 1'b0;
  logic      m0_req_valid = 1'b0, m1_req_valid = 1'b0;
  logic      m0_req_ready, m1_req_ready;
  mem_req_t  m0_req = '0, m1_req = '0;
  logic      m0_resp_valid, m1_resp_valid;
  logic      m0_resp_ready = 1'b1, m1_resp_ready = 1'b1;
  mem_resp_t m0_resp, m1_resp;
  logic      sn_req_valid;
  logic      sn_req_ready = 1'b0;
  mem_req_t  sn_req;
  logic      sn_resp_valid, sn_resp_ready;
  mem_resp_t sn_resp;
  logic      err_unexp_resp;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_gnt0, perf_gnt1, perf_conf, perf_full;
`endif

  logic      auto_slave = 1'b0;
  logic      slv_valid = 1'b0, man_valid = 1'b0;
  mem_resp_t slv_resp = '0, man_resp = '0;
  assign sn_resp_valid = auto_slave ? slv_valid : man_valid;
  assign sn_resp       = auto_slave ? slv_resp : man_resp;

  int          n_vec = 0, n_err = 0, cyc = 0;
  mem_req_t    pq0[$], pq1[$];
  logic [31:0] sq[$];
  int          glog[$], gcyc[$];
  logic [31:0] r0[$], r1[$];
  bit          m1v_seen = 1'b0;

  mem_arb_2to1 #(.OUTSTD(OUTSTD)) dut (
    .clk(clk), .rstn(rstn),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req(m0_req),
    .m0_resp_valid(m0_resp_valid), .m0_resp_ready(m0_resp_ready), .m0_resp(m0_resp),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req(m1_req),
    .m1_resp_valid(m1_resp_valid), .m1_resp_ready(m1_resp_ready), .m1_resp(m1_resp),
    .sn_req_valid(sn_req_valid), .sn_req_ready(sn_req_ready), .sn_req(sn_req),
    .sn_resp_valid(sn_resp_valid), .sn_resp_ready(sn_resp_ready), .sn_resp(sn_resp),
    .err_unexp_resp(err_unexp_resp)
`ifdef MEM_ARB_PERF_EN
    , .perf_gnt0(perf_gnt0), .perf_gnt1(perf_gnt1), .perf_conf(perf_conf), .perf_full(perf_full)
`endif
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial begin
    #200000;
    $display("FAIL watchdog: no summary after 200000 time units");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic mem_req_t mkreq(input logic [31:0] a);
    mem_req_t r;
    r.we = 1'b0; r.be = 4'hF; r.addr = a; r.wdata = ~a;
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstn = 1'b0;
    pq0.delete(); pq1.delete(); sq.delete();
    sn_req_ready = 1'b0; man_valid = 1'b0;
    m0_resp_ready = 1'b1; m1_resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    glog.delete(); gcyc.delete(); r0.delete(); r1.delete();
    m1v_seen = 1'b0;
  endtask

  // Reference model: outstanding master IDs as a queue, preference bit and a held grant.
  initial begin : cmp
    int mq[$];
    bit pref, mfull, exp_snv, exp_srr, was_empty, hsq;
    int stuck, g, h;
    bit merr;
    pref = 1'b0; stuck = -1; merr = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        mq.delete(); pref = 1'b0; stuck = -1; merr = 1'b0;
        chk("rst_err", err_unexp_resp, 0);
        chk("rst_sn_req_valid", sn_req_valid, 0);
        chk("rst_m0_req_ready", m0_req_ready, 0);
        chk("rst_m1_req_ready", m1_req_ready, 0);
        chk("rst_resp_valid", {m0_resp_valid, m1_resp_valid}, 0);
        chk("rst_sn_resp_ready", sn_resp_ready, 0);
      end else begin
        mfull = (mq.size() == OUTSTD);
        if (stuck >= 0)                        g = stuck;
        else if (m0_req_valid && m1_req_valid) g = int'(pref);
        else                                   g = m1_req_valid ? 1 : 0;
        exp_snv = !mfull && ((g == 1) ? m1_req_valid : m0_req_valid);
        chk("sn_req_valid", sn_req_valid, exp_snv);
        if (exp_snv) chk("sn_req", sn_req, (g == 1) ? m1_req : m0_req);
        chk("m0_req_ready", m0_req_ready, sn_req_ready && !mfull && g == 0);
        chk("m1_req_ready", m1_req_ready, sn_req_ready && !mfull && g == 1);

        was_empty = (mq.size() == 0);
        if (!was_empty) begin
          h = mq[0];
          exp_srr = (h == 1) ? m1_resp_ready : m0_resp_ready;
          chk("m0_resp_valid", m0_resp_valid, sn_resp_valid && h == 0);
          chk("m1_resp_valid", m1_resp_valid, sn_resp_valid && h == 1);
          if (sn_resp_valid) chk("resp_payload", (h == 1) ? m1_resp : m0_resp, sn_resp);
        end else begin
          exp_srr = sn_resp_valid;
          chk("resp_valid_empty", {m0_resp_valid, m1_resp_valid}, 0);
        end
        chk("sn_resp_ready", sn_resp_ready, exp_srr);
        chk("err_unexp_resp", err_unexp_resp, merr);

        if (sn_req_valid && sn_req_ready) begin
          glog.push_back(m1_req_ready ? 1 : 0);
          gcyc.push_back(cyc);
        end
        if (m0_resp_valid && m0_resp_ready) r0.push_back(m0_resp.rdata);
        if (m1_resp_valid && m1_resp_ready) r1.push_back(m1_resp.rdata);
        if (m1_resp_valid) m1v_seen = 1'b1;

        if (!was_empty && sn_resp_valid && exp_srr) void'(mq.pop_front());
        if (was_empty && sn_resp_valid) merr = 1'b1;
        hsq = exp_snv && sn_req_ready;
        if (hsq) begin
          mq.push_back(g);
          pref  = (g == 0);
          stuck = -1;
        end else if (exp_snv) begin
          stuck = g;
        end
      end
    end
  end

  // Master request generators: present the queue head until it is accepted.
  initial begin : mgen
    bit h0, h1;
    forever begin
      @(negedge clk);
      h0 = m0_req_valid && m0_req_ready;
      h1 = m1_req_valid && m1_req_ready;
      @(posedge clk); #3;
      if (h0 && pq0.size() > 0) void'(pq0.pop_front());
      if (h1 && pq1.size() > 0) void'(pq1.pop_front());
      m0_req_valid = (pq0.size() > 0);
      m1_req_valid = (pq1.size() > 0);
      if (pq0.size() > 0) m0_req = pq0[0];
      if (pq1.size() > 0) m1_req = pq1[0];
    end
  end

  // In-order slave answering one cycle after acceptance with rdata = addr + RSP_OFS.
  initial begin : sgen
    bit hr, hq;
    logic [31:0] qa;
    forever begin
      @(negedge clk);
      hr = sn_resp_valid && sn_resp_ready;
      hq = sn_req_valid && sn_req_ready;
      qa = sn_req.addr;
      @(posedge clk); #3;
      if (auto_slave && hr && sq.size() > 0) void'(sq.pop_front());
      if (auto_slave && hq && rstn) sq.push_back(qa);
      slv_valid      = (sq.size() > 0);
      slv_resp.err   = 1'b0;
      slv_resp.rdata = (sq.size() > 0) ? sq[0] + RSP_OFS : 32'h0;
    end
  end

  initial begin : stim
    int c0, c1;
    int exp_alt[8];
    exp_alt = '{0, 1, 0, 1, 0, 1, 0, 1};
    do_reset();

    // m0 alone, slave always ready: back-to-back issue, in-order responses
    auto_slave = 1'b1; sn_req_ready = 1'b1;
    for (int i = 0; i < 8; i++) pq0.push_back(mkreq(32'h100 + i));
    for (int k = 0; k < 60 && r0.size() < 8; k++) tick(1);
    chk("t1_resp_count", r0.size(), 8);
    for (int i = 0; i < r0.size(); i++) chk("t1_resp_data", r0[i], 32'h1000_0100 + i);
    chk("t1_m1_resp_seen", m1v_seen, 0);
    chk("t1_back_to_back", (gcyc.size() == 8) ? gcyc[7] - gcyc[0] : -1, 7);

    // both masters always valid: grants alternate starting with m0
    do_reset();
    auto_slave = 1'b1; sn_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pq0.push_back(mkreq(32'h200 + i));
      pq1.push_back(mkreq(32'h300 + i));
    end
    for (int k = 0; k < 40 && r1.size() < 4; k++) tick(1);
    chk("t2_grant_count", glog.size(), 8);
    for (int i = 0; i < glog.size() && i < 8; i++) chk("t2_grant_order", glog[i], exp_alt[i]);
    chk("t2_m1_last_resp", (r1.size() == 4) ? r1[3] : 32'h0, 32'h1000_0303);

    // stalled m1 keeps the grant although m0 arrives and is preferred
    do_reset();
    auto_slave = 1'b1; sn_req_ready = 1'b0;
    c0 = cyc;
    pq1.push_back(mkreq(32'h400));
    tick(1); pq0.push_back(mkreq(32'h500));
    tick(2); sn_req_ready = 1'b1;
    tick(4);
    chk("t3_grant_count", glog.size(), 2);
    chk("t3_first_m1", (glog.size() > 0) ? glog[0] : -1, 1);
    chk("t3_then_m0", (glog.size() > 1) ? glog[1] : -1, 0);
    chk("t3_m1_cycle", (gcyc.size() > 0) ? gcyc[0] - c0 : -1, 3);
    chk("t3_m0_cycle", (gcyc.size() > 1) ? gcyc[1] - c0 : -1, 4);

    // slave withholds responses: fifth request waits for a free slot
    do_reset();
    auto_slave = 1'b0; sn_req_ready = 1'b1;
    for (int i = 0; i < 5; i++) pq0.push_back(mkreq(32'h600 + i));
    tick(8);
    mid();
    chk("t4_accepted", glog.size(), 4);
    chk("t4_stall_valid", m0_req_valid, 1);
    chk("t4_stall_ready", m0_req_ready, 0);
    tick(1);
    man_valid = 1'b1; man_resp = '{err: 1'b0, rdata: 32'h1000_0600};
    c1 = cyc;
    mid();
    chk("t4_resp_taken", sn_resp_ready, 1);
    tick(1); man_valid = 1'b0;
    mid();
    chk("t4_fifth_ready", m0_req_ready, 1);
    chk("t4_fifth_cycle", (gcyc.size() == 5) ? gcyc[4] - c1 : -1, 1);
    chk("t4_resp_data", (r0.size() > 0) ? r0[0] : 32'h0, 32'h1000_0600);

    // m0 holds off its response: slave is stalled, payload kept, order preserved
    do_reset();
    auto_slave = 1'b0; sn_req_ready = 1'b1;
    m0_resp_ready = 1'b0; m1_resp_ready = 1'b1;
    pq0.push_back(mkreq(32'h700)); pq1.push_back(mkreq(32'h800));
    tick(3);
    man_valid = 1'b1; man_resp = '{err: 1'b0, rdata: 32'hBEEF_0000};
    mid();
    chk("t5_hold1_ready", sn_resp_ready, 0);
    chk("t5_hold1_m0v", m0_resp_valid, 1);
    chk("t5_hold1_m1v", m1_resp_valid, 0);
    tick(1); mid();
    chk("t5_hold2_ready", sn_resp_ready, 0);
    chk("t5_hold2_data", m0_resp.rdata, 32'hBEEF_0000);
    tick(1); m0_resp_ready = 1'b1;
    mid();
    chk("t5_release", sn_resp_ready, 1);
    tick(1); man_resp = '{err: 1'b0, rdata: 32'hCAFE_0001};
    mid();
    chk("t5_m1_valid", m1_resp_valid, 1);
    chk("t5_m0_idle", m0_resp_valid, 0);
    tick(1); man_valid = 1'b0;
    tick(1);
    chk("t5_m0_count", r0.size(), 1);
    chk("t5_m0_data", (r0.size() > 0) ? r0[0] : 32'h0, 32'hBEEF_0000);
    chk("t5_m1_count", r1.size(), 1);
    chk("t5_m1_data", (r1.size() > 0) ? r1[0] : 32'h0, 32'hCAFE_0001);

    // unexpected response: dropped, sticky error until reset
    do_reset();
    auto_slave = 1'b0;
    man_valid = 1'b1; man_resp = '{err: 1'b0, rdata: 32'h0000_DEAD};
    mid();
    chk("t6_drop_ready", sn_resp_ready, 1);
    chk("t6_no_route", {m0_resp_valid, m1_resp_valid}, 0);
    chk("t6_err_before", err_unexp_resp, 0);
    tick(1); man_valid = 1'b0;
    mid();
    chk("t6_err_set", err_unexp_resp, 1);
`ifdef MEM_ARB_PERF_EN
    sn_req_ready = 1'b1;
    pq0.push_back(mkreq(32'h900));
    tick(3); mid();
    chk("t6_perf_gnt0", perf_gnt0, 1);
    chk("t6_perf_gnt1", perf_gnt1, 0);
`else
    tick(3); mid();
`endif
    chk("t6_err_sticky", err_unexp_resp, 1);
    do_reset();
    mid();
    chk("t6_err_cleared", err_unexp_resp, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
